// File: rtl/serial_rx_if.sv
// Receive-side handshake bundle: serial line in, byte stream plus status out.
// The receiver drives the byte stream; the consumer holds the slave side.
interface serial_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 busy_o;

  modport master (
    input  serial_i, ready_i,
    output data_o, valid_o, frame_err_o, overrun_o, busy_o
  );

  modport slave (
    output serial_i, ready_i,
    input  data_o, valid_o, frame_err_o, overrun_o, busy_o
  );
endinterface

// File: rtl/serial_rx.sv
// Serial-to-parallel receiver: start/data/stop framing, sampling at mid-bit,
// byte handed out on a valid/ready port with framing-error and overrun pulses.
module serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  serial_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_sync;
  logic                 w_s;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bits;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_ferr, r_ovr;
  logic                 w_cnt_clr, w_shift, w_deliver, w_ferr;

  assign w_s = r_sync[1];

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_shift   = 1'b0;
    w_deliver = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      IDLE: if (!w_s) begin
        w_next    = START;
        w_cnt_clr = 1'b1;
      end
      START: if (r_cnt == HALF_M1) begin
        w_cnt_clr = 1'b1;
        w_next    = w_s ? IDLE : DATA;
      end
      DATA: if (r_cnt == FULL_M1) begin
        w_cnt_clr = 1'b1;
        w_shift   = 1'b1;
        if (r_bits == LAST_BIT) w_next = STOP;
      end
      STOP: if (r_cnt == FULL_M1) begin
        w_cnt_clr = 1'b1;
        if (w_s) begin
          w_deliver = 1'b1;
          w_next    = IDLE;
        end else begin
          w_ferr = 1'b1;
          w_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (w_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.serial_i};
      r_state <= w_next;

      if (w_cnt_clr || r_state == IDLE || r_state == WAIT_IDLE) r_cnt <= '0;
      else                                                      r_cnt <= r_cnt + CW'(1);

      // Bit count only matters inside DATA; any other state re-arms it.
      if (r_state != DATA) r_bits <= '0;
      else if (w_shift)    r_bits <= r_bits + BW'(1);

      if (w_shift) r_shift <= {w_s, r_shift[DATA_BITS-1:1]};

      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || bus.ready_i) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_o      = r_data;
  assign bus.valid_o     = r_valid;
  assign bus.frame_err_o = r_ferr;
  assign bus.overrun_o   = r_ovr;
  assign bus.busy_o      = (r_state != IDLE);
endmodule
